// File: rtl/fifo_rd_stage_if.sv
// Stream-side and controller-side signal bundle for the FIFO read stage.
interface fifo_rd_stage_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned LW = 2
);
  logic          i_empty;
  logic          o_rd;
  logic [DW-1:0] i_rdata;
  logic          i_flush;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic [LW-1:0] o_level;

  // The read stage itself
  modport slave (
    input  i_empty, i_rdata, i_flush, i_ready,
    output o_rd, o_valid, o_data, o_level
  );

  // Controller, storage and consumer side
  modport master (
    output i_empty, i_rdata, i_flush, i_ready,
    input  o_rd, o_valid, o_data, o_level
  );
endinterface

// File: rtl/fifo_rd_stage.sv
// FIFO read stage: credit-based pop issue, fixed-latency capture into a
// skid buffer, and a registered valid/ready stream output.
module fifo_rd_stage #(
  parameter int unsigned DW        = 8,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic           i_clk,
  input  logic           i_rst,
  fifo_rd_stage_if.slave bus
);

  localparam int unsigned LW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  // Reject parameter sets the credit scheme cannot support
  generate
    if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
      $error("fifo_rd_stage: RD_LAT must be 1..3");
    end
    if (BUF_DEPTH < RD_LAT + 1) begin : g_bad_depth
      $error("fifo_rd_stage: BUF_DEPTH must be >= RD_LAT+1");
    end
  endgenerate

  logic [RD_LAT-1:0] r_pipe;
  logic [DW-1:0]     r_mem [BUF_DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [LW-1:0]     r_level;
  logic [LW-1:0]     r_cnt;
  logic              r_valid;
  logic [DW-1:0]     r_data;

  logic              w_rd;
  logic              w_arrive;
  logic              w_pop;
  logic [PW-1:0]     w_head_nxt;
  logic [LW-1:0]     w_level_nxt;
  logic [LW-1:0]     w_cnt_nxt;
  logic [DW-1:0]     w_data_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Pop issue depends only on registered credit and the controller empty flag
  assign w_rd     = ~i_rst & ~bus.i_flush & ~bus.i_empty & (r_cnt < LW'(BUF_DEPTH));
  assign w_arrive = r_pipe[RD_LAT-1];
  assign w_pop    = r_valid & bus.i_ready;

  // Next-state values for pointers, occupancy, credit and the head word
  always_comb begin
    w_head_nxt  = w_pop ? ptr_inc(r_head) : r_head;
    w_level_nxt = r_level + LW'(w_arrive) - LW'(w_pop);
    w_cnt_nxt   = r_cnt + LW'(w_rd) - LW'(w_pop);
    // New head equals the tail being written only when the buffer drains to empty
    if (w_arrive && (r_tail == w_head_nxt)) begin
      w_data_nxt = bus.i_rdata;
    end else begin
      w_data_nxt = r_mem[w_head_nxt];
    end
  end

  // Valid shift pipe tracking pops whose read data is still in flight
  always_ff @(posedge i_clk) begin
    if (i_rst || bus.i_flush) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= w_rd;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  // Skid buffer storage, written at the tail when read data lands
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (!bus.i_flush && w_arrive) begin
      r_mem[r_tail] <= bus.i_rdata;
    end
  end

  // Pointers, occupancy, credit and the registered stream head
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_level <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (bus.i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_level <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_head  <= w_head_nxt;
      r_tail  <= w_arrive ? ptr_inc(r_tail) : r_tail;
      r_level <= w_level_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= (w_level_nxt != '0);
      r_data  <= w_data_nxt;
    end
  end

  // Credit accounting must make an arrival into a full buffer impossible
  always_ff @(posedge i_clk) begin
    if (!i_rst && !bus.i_flush) begin
      assert (!(w_arrive && (r_level == LW'(BUF_DEPTH))));
      assert (r_cnt <= LW'(BUF_DEPTH));
    end
  end

  assign bus.o_rd    = w_rd;
  assign bus.o_valid = r_valid;
  assign bus.o_data  = r_data;
  assign bus.o_level = r_level;

endmodule

// File: tb/tb_fifo_rd_stage.sv
// Bench for fifo_rd_stage: DUT a (RD_LAT=1, BUF_DEPTH=2) and
// DUT b (RD_LAT=2, BUF_DEPTH=4), each fed by a counting source model.
module tb_fifo_rd_stage;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fifo_rd_stage_if #(.DW(8), .LW(2)) bus_a ();
  fifo_rd_stage_if #(.DW(8), .LW(3)) bus_b ();

  fifo_rd_stage #(.DW(8), .RD_LAT(1), .BUF_DEPTH(2)) u_a (
    .i_clk (clk),
    .i_rst (rst_a),
    .bus   (bus_a)
  );

  fifo_rd_stage #(.DW(8), .RD_LAT(2), .BUF_DEPTH(4)) u_b (
    .i_clk (clk),
    .i_rst (rst_b),
    .bus   (bus_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Source / storage model for a: words counted from 0x10, one cycle latency
  logic [7:0] a_src = 8'h10;
  logic [7:0] a_exp = 8'h10;
  logic [7:0] a_word;
  logic       a_fire = 1'b0;
  logic       a_hold = 1'b0;
  logic [7:0] a_hold_data;
  int         a_pops = 0;

  always @(negedge clk) begin
    if (a_hold) check("a_hold_valid", bus_a.o_valid, 1'b1);
    if (a_hold) check("a_hold_data", bus_a.o_data, a_hold_data);
    a_fire = bus_a.o_rd;
    a_word = a_src;
    if (a_fire === 1'b1) a_src = a_src + 8'd1;
    if (bus_a.o_valid === 1'b1 && bus_a.i_ready === 1'b1) begin
      check("a_order", bus_a.o_data, a_exp);
      a_exp  = a_exp + 8'd1;
      a_pops = a_pops + 1;
    end
    if (rst_a === 1'b1 || bus_a.i_flush === 1'b1) a_exp = a_src;
    a_hold = (bus_a.o_valid === 1'b1) && (bus_a.i_ready === 1'b0) &&
             (rst_a === 1'b0) && (bus_a.i_flush === 1'b0);
    a_hold_data = bus_a.o_data;
  end

  always @(posedge clk) begin
    #1;
    bus_a.i_rdata = (a_fire === 1'b1) ? a_word : 8'hEE;
  end

  // Source / storage model for b: words counted from 0x20, two cycle latency
  logic [7:0] b_src = 8'h20;
  logic [7:0] b_exp = 8'h20;
  logic [7:0] b_word;
  logic       b_fire = 1'b0;
  logic [7:0] b_lat0 = 8'hEE;

  always @(negedge clk) begin
    b_fire = bus_b.o_rd;
    b_word = b_src;
    if (b_fire === 1'b1) b_src = b_src + 8'd1;
    if (bus_b.o_valid === 1'b1 && bus_b.i_ready === 1'b1) begin
      check("b_order", bus_b.o_data, b_exp);
      b_exp = b_exp + 8'd1;
    end
    if (rst_b === 1'b1 || bus_b.i_flush === 1'b1) b_exp = b_src;
  end

  always @(posedge clk) begin
    #1;
    bus_b.i_rdata = b_lat0;
    b_lat0 = (b_fire === 1'b1) ? b_word : 8'hEE;
  end

  typedef struct {
    logic       rst;
    logic       empty;
    logic       ready;
    logic       flush;
    logic       exp_rd;
    logic       exp_valid;
    logic [1:0] exp_level;
  } vec_t;

  vec_t tbl [16];
  int   pops_before;

  initial begin
    // rst empty ready flush | rd valid level  (DUT a, cycle by cycle)
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};

    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.i_empty = 1'b0; bus_a.i_ready = 1'b0; bus_a.i_flush = 1'b0;
    bus_b.i_empty = 1'b1; bus_b.i_ready = 1'b0; bus_b.i_flush = 1'b0;
    step();
    step();

    // Reset state, with i_empty=0 on a
    @(negedge clk);
    check("a_rst_rd", bus_a.o_rd, 1'b0);
    check("a_rst_valid", bus_a.o_valid, 1'b0);
    check("a_rst_data", bus_a.o_data, 8'h00);
    check("a_rst_level", bus_a.o_level, 2'd0);
    check("b_rst_valid", bus_b.o_valid, 1'b0);

    // Table: first pop after reset, latency, credit stall, backpressure, empty, flush
    for (int i = 0; i < 16; i++) begin
      step();
      rst_a         = tbl[i].rst;
      bus_a.i_empty = tbl[i].empty;
      bus_a.i_ready = tbl[i].ready;
      bus_a.i_flush = tbl[i].flush;
      @(negedge clk);
      check($sformatf("a_vec%0d_rd", i), bus_a.o_rd, tbl[i].exp_rd);
      check($sformatf("a_vec%0d_valid", i), bus_a.o_valid, tbl[i].exp_valid);
      check($sformatf("a_vec%0d_level", i), bus_a.o_level, tbl[i].exp_level);
    end

    // Empty toggling every two cycles; ordering checked by the scoreboard
    for (int k = 0; k < 24; k++) begin
      step();
      bus_a.i_empty = 1'((k / 2) % 2);
      bus_a.i_ready = 1'b1;
    end

    // Random empty/backpressure: credit bound and in-order delivery
    pops_before = a_pops;
    for (int k = 0; k < 10000; k++) begin
      step();
      bus_a.i_empty = 1'($urandom_range(0, 1));
      bus_a.i_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      check("a_level_bound", (bus_a.o_level <= 2'd2), 1'b1);
    end
    check("a_progress", (a_pops - pops_before) >= 1000, 1'b1);
    step();
    bus_a.i_empty = 1'b1;

    // b streaming: o_valid exactly RD_LAT+1 cycles after first o_rd, then no bubbles
    rst_b = 1'b0;
    bus_b.i_empty = 1'b0;
    bus_b.i_ready = 1'b1;
    @(negedge clk);
    check("b_first_rd", bus_b.o_rd, 1'b1);
    for (int k = 1; k < 11; k++) begin
      step();
      @(negedge clk);
      check($sformatf("b_stream_valid%0d", k), bus_b.o_valid, (k >= 3));
    end

    // Mid-stream reset clears everything including output data
    step();
    rst_b = 1'b1;
    bus_b.i_ready = 1'b0;
    @(negedge clk);
    check("b_rst_rd", bus_b.o_rd, 1'b0);
    step();
    rst_b = 1'b0;
    bus_b.i_empty = 1'b0;
    @(negedge clk);
    check("b_rst2_valid", bus_b.o_valid, 1'b0);
    check("b_rst2_data", bus_b.o_data, 8'h00);
    check("b_rst2_level", bus_b.o_level, 3'd0);

    // Build two buffered words plus one in flight, then flush
    step();
    step();
    step();
    bus_b.i_empty = 1'b1;
    step();
    bus_b.i_flush = 1'b1;
    @(negedge clk);
    check("b_preflush_level", bus_b.o_level, 3'd2);
    check("b_preflush_valid", bus_b.o_valid, 1'b1);
    check("b_flush_rd", bus_b.o_rd, 1'b0);
    step();
    bus_b.i_flush = 1'b0;
    bus_b.i_empty = 1'b0;
    bus_b.i_ready = 1'b1;
    @(negedge clk);
    check("b_postflush_valid", bus_b.o_valid, 1'b0);
    check("b_postflush_level", bus_b.o_level, 3'd0);
    check("b_postflush_rd", bus_b.o_rd, 1'b1);
    step();
    @(negedge clk);
    check("b_postflush_valid1", bus_b.o_valid, 1'b0);
    step();
    @(negedge clk);
    check("b_postflush_valid2", bus_b.o_valid, 1'b0);
    step();
    @(negedge clk);
    check("b_postflush_valid3", bus_b.o_valid, 1'b1);
    for (int k = 0; k < 6; k++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
